// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_conditioner
// Brief    : SCL/SDA synchronizer, glitch filter, edge/START/STOP detection
//            and hold-time-controlled open-drain SDA enable for an I2C slave.
// Revision : 1.0
// ============================================================================
module i2c_bus_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int FILTER_CYCLES   = 5,
    parameter int SDA_HOLD_CYCLES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_raw,
    input  logic sda_raw,
    input  logic sda_low_req,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic sda_oe
);

    localparam int c_FILT_W = $clog2(FILTER_CYCLES + 1);
    localparam int c_HOLD_W = $clog2(SDA_HOLD_CYCLES + 1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(SDA_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {sda_raw, scl_raw};

    // Index 0 is SCL, index 1 is SDA; both lines get identical latency.
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q;
        logic [c_FILT_W-1:0]    cnt_q;
        logic                   filt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '1;
                cnt_q  <= '0;
                filt_q <= 1'b1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], w_raw[gi]};
                if (sync_q[SYNC_STAGES-1] == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == c_FILT_LAST) begin
                    filt_q <= sync_q[SYNC_STAGES-1];
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + c_FILT_W'(1);
                end
            end
        end

        assign w_filt[gi] = filt_q;
    end

    logic [1:0] filt_d_q;
    logic       scl_rise_q;
    logic       scl_fall_q;
    logic       start_q;
    logic       stop_q;
    logic       busy_q;
    logic       w_scl_stable_hi;

    // START/STOP only qualify when SCL was high on both sides of the SDA edge.
    assign w_scl_stable_hi = w_filt[0] & filt_d_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_d_q   <= 2'b11;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            filt_d_q   <= w_filt;
            scl_rise_q <= w_filt[0] & ~filt_d_q[0];
            scl_fall_q <= ~w_filt[0] & filt_d_q[0];
            start_q    <= w_scl_stable_hi & filt_d_q[1] & ~w_filt[1];
            stop_q     <= w_scl_stable_hi & ~filt_d_q[1] & w_filt[1];
            if (start_q) begin
                busy_q <= 1'b1;
            end else if (stop_q) begin
                busy_q <= 1'b0;
            end
        end
    end

    state_t              state_q;
    state_t              state_d;
    logic [c_HOLD_W-1:0] hold_cnt_q;
    logic [c_HOLD_W-1:0] hold_cnt_d;
    logic                sda_oe_q;
    logic                sda_oe_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        sda_oe_d   = sda_oe_q;
        if (start_q || stop_q || !busy_q) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (scl_fall_q) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = c_HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (scl_rise_q) begin
                        state_d = ST_IDLE;
                    end else if (hold_cnt_q == '0) begin
                        state_d = ST_OPEN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - c_HOLD_W'(1);
                    end
                end
                ST_OPEN: begin
                    if (scl_rise_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        sda_oe_d = sda_low_req;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign scl_f     = w_filt[0];
    assign sda_f     = w_filt[1];
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign bus_busy  = busy_q;
    assign sda_oe    = sda_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_conditioner
// Brief    : Randomized + directed bench; reference model predicts output
//            changes into a queue that a negedge monitor consumes.
// Revision : 1.0
// ============================================================================
module tb_i2c_bus_conditioner;

    localparam int SYNC   = 2;
    localparam int FILT   = 5;
    localparam int HOLD   = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_raw = 1'b0;
    logic sda_raw = 1'b0;
    logic sda_low_req = 1'b0;
    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, sda_oe;

    i2c_bus_conditioner #(
        .SYNC_STAGES    (SYNC),
        .FILTER_CYCLES  (FILT),
        .SDA_HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_raw    (scl_raw),
        .sda_raw    (sda_raw),
        .sda_low_req(sda_low_req),
        .scl_f      (scl_f),
        .sda_f      (sda_f),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .bus_busy   (bus_busy),
        .sda_oe     (sda_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } ev_t;
    ev_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Direct level checks requested by the stimulus thread.
    int         chk_id = 0;
    int         chk_seen = 0;
    logic [7:0] chk_m = '0;
    logic [7:0] chk_v = '0;
    string      chk_name = "";

    // Reference model: output vector {scl_f,sda_f,rise,fall,start,stop,busy,oe}.
    bit   m_sq[$];
    bit   m_dq[$];
    logic m_scl, m_sda, m_scl_p, m_sda_p;
    logic m_rise, m_fall, m_start, m_stop, m_busy, m_oe, m_armed;
    int   m_run_s, m_run_d, m_fall_seen;
    logic [7:0] m_vec = 8'hC0;

    task automatic model_reset();
        m_sq.delete();
        m_dq.delete();
        for (int i = 0; i < SYNC; i++) begin
            m_sq.push_back(1'b1);
            m_dq.push_back(1'b1);
        end
        m_scl = 1'b1; m_sda = 1'b1; m_scl_p = 1'b1; m_sda_p = 1'b1;
        m_rise = 1'b0; m_fall = 1'b0; m_start = 1'b0; m_stop = 1'b0;
        m_busy = 1'b0; m_oe = 1'b0; m_armed = 1'b0;
        m_run_s = 0; m_run_d = 0; m_fall_seen = 0;
    endtask

    // A filtered level follows its synced input once the new value has been
    // seen FILT consecutive cycles.
    task automatic filt_step(input logic s, inout logic f, inout int run);
        if (s != f) begin
            run++;
            if (run == FILT) begin
                f   = s;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_step();
        int         t;
        logic       n_rise, n_fall, n_start, n_stop, n_busy, hi, s;
        logic [7:0] v;
        ev_t        e;
        t = cyc + 1;
        if (rst) begin
            model_reset();
        end else begin
            hi      = m_scl & m_scl_p;
            n_rise  = m_scl & ~m_scl_p;
            n_fall  = ~m_scl & m_scl_p;
            n_start = hi & m_sda_p & ~m_sda;
            n_stop  = hi & ~m_sda_p & m_sda;
            n_busy  = m_start ? 1'b1 : (m_stop ? 1'b0 : m_busy);
            if (m_start || m_stop || !m_busy) begin
                m_oe    = 1'b0;
                m_armed = 1'b0;
            end else if (m_armed) begin
                if (m_rise) m_armed = 1'b0;
                else if (t >= m_fall_seen + HOLD + 1) m_oe = sda_low_req;
            end else if (m_fall) begin
                m_armed     = 1'b1;
                m_fall_seen = t;
            end
            m_scl_p = m_scl;
            m_sda_p = m_sda;
            s = m_sq.pop_front();
            m_sq.push_back(scl_raw);
            filt_step(s, m_scl, m_run_s);
            s = m_dq.pop_front();
            m_dq.push_back(sda_raw);
            filt_step(s, m_sda, m_run_d);
            m_rise = n_rise; m_fall = n_fall; m_start = n_start; m_stop = n_stop;
            m_busy = n_busy;
        end
        v = {m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_oe};
        if (v !== m_vec) begin
            e.cyc = t;
            e.v   = v;
            exp_q.push_back(e);
            m_vec = v;
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic q, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = r; scl_raw = s; sda_raw = d; sda_low_req = q;
            model_step();
        end
    endtask

    // Checks the outputs produced by the edge that applied the last drive.
    task automatic req_check(input logic [7:0] m, input logic [7:0] v, input string name);
        #1;
        chk_m = m; chk_v = v; chk_name = name;
        chk_id++;
    endtask

    logic [7:0] prev = 8'hC0;
    always @(negedge clk) begin : monitor
        logic [7:0] cur;
        ev_t        e;
        if (cyc >= 1) begin
            cur = {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, sda_oe};
            if (cur !== prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.v !== cur) begin
                        n_bad++;
                        $display("FAIL event cyc=%0d got=%b required=%b at cyc %0d", cyc, cur, e.v, e.cyc);
                    end
                end
                prev = cur;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event cyc=%0d got=%b required=%b at cyc %0d", cyc, cur, e.v, e.cyc);
            end
            if (chk_id != chk_seen) begin
                chk_seen = chk_id;
                n_cmp++;
                if ((cur & chk_m) !== chk_v) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%b required=%b mask=%b", chk_name, cyc, cur & chk_m, chk_v, chk_m);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r;
        model_reset();
        // T1: reset with both raw lines low
        drive(1, 0, 0, 0, 3);
        req_check(8'hFF, 8'hC0, "reset_state");
        drive(0, 0, 0, 0, 12);
        drive(0, 1, 1, 0, 20);
        // T2: glitch rejection, then a minimum-width pulse
        drive(0, 0, 1, 0, 4);
        drive(0, 1, 1, 0, 15);
        req_check(8'h80, 8'h80, "glitch_rejected");
        drive(0, 0, 1, 0, 5);
        drive(0, 1, 1, 0, 15);
        // T3: START, one data bit, STOP
        drive(0, 1, 0, 0, 15);
        req_check(8'h02, 8'h02, "busy_after_start");
        drive(0, 0, 0, 0, 10);
        drive(0, 0, 1, 0, 10);
        drive(0, 1, 1, 0, 15);
        drive(0, 0, 1, 0, 10);
        drive(0, 0, 0, 0, 10);
        drive(0, 1, 0, 0, 15);
        drive(0, 1, 1, 0, 15);
        req_check(8'h02, 8'h00, "idle_after_stop");
        // T4: START then repeated START
        drive(0, 1, 0, 0, 15);
        drive(0, 0, 0, 0, 10);
        drive(0, 0, 1, 0, 10);
        drive(0, 1, 1, 0, 15);
        drive(0, 1, 0, 0, 15);
        req_check(8'h02, 8'h02, "busy_after_rstart");
        // T6: simultaneous SCL/SDA edges while busy
        drive(0, 0, 0, 0, 10);
        drive(0, 0, 1, 0, 10);
        drive(0, 1, 1, 0, 15);
        drive(0, 0, 0, 0, 15);
        drive(0, 1, 1, 0, 15);
        req_check(8'h02, 8'h02, "busy_after_simul");
        drive(0, 0, 0, 0, 10);
        drive(0, 1, 0, 0, 15);
        drive(0, 1, 1, 0, 15);
        req_check(8'h02, 8'h00, "idle_after_stop2");
        // T5: SDA hold after SCL falls
        drive(0, 1, 0, 0, 15);
        drive(0, 0, 0, 0, 10);
        drive(0, 0, 1, 0, 10);
        drive(0, 1, 1, 1, 20);
        req_check(8'h01, 8'h00, "oe_low_scl_high");
        drive(0, 0, 1, 1, 25);
        req_check(8'h01, 8'h00, "oe_low_in_hold");
        drive(0, 0, 1, 1, 25);
        req_check(8'h01, 8'h01, "oe_after_hold");
        drive(0, 1, 1, 1, 20);
        req_check(8'h01, 8'h01, "oe_kept_scl_high");
        drive(0, 0, 1, 1, 50);
        req_check(8'h03, 8'h03, "busy_oe_before_rst");
        // T7: reset pulse mid-transfer
        drive(1, 0, 1, 1, 1);
        req_check(8'h03, 8'h00, "rst_releases");
        drive(0, 1, 1, 0, 20);
        // Random segments
        for (int i = 0; i < 80; i++) begin
            r = ($urandom_range(0, 40) == 0);
            drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), r ? 1 : int'($urandom_range(1, 40)));
        end
        drive(0, 1, 1, 0, 60);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
